// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Control bundle between the multicycle sequencer and the shared datapath.
//
// Signals (direction seen from the controller / master side):
//   instruction  in  32  IR contents, valid from DECODE onward
//   mem_ready    in   1  memory completes the current request this cycle
//   alu_zero     in   1  ALU result == 0, combinational from datapath
//   mem_req      out  1  memory request, held until mem_ready
//   mem_we       out  1  write strobe qualifying mem_req
//   mem_addr_sel out  1  0 = PC, 1 = ALUOut
//   ir_write     out  1  latch memory read data into IR
//   pc_write     out  1  load PC
//   pc_src       out  2  0 = PC+4, 1 = ALUOut, 2 = jump target
//   alu_src_a    out  1  0 = PC, 1 = rs data
//   alu_src_b    out  2  0 = rt, 1 = 4, 2 = sext(imm), 3 = sext(imm)<<2
//   alu_op       out  3  ALU operation code
//   reg_write    out  1  register file write enable
//   reg_dst      out  1  0 = rt, 1 = rd
//   mem_to_reg   out  1  0 = ALUOut, 1 = memory data register
//   state        out  3  current state (debug)
//   illegal      out  1  undecoded instruction trapped
//   retired      out 32  completed-instruction count
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] retired;

    modport master (
        input  instruction, mem_ready, alu_zero,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               state, illegal, retired
    );

    modport slave (
        output instruction, mem_ready, alu_zero,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               state, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// FSM sequencer for a single-memory-port multicycle datapath. Walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, traps undecoded
// instructions, and counts retired instructions.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      master side of multicycle_control_if (datapath controls)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_retired;
    logic        w_retire;
    logic [5:0]  w_opcode;
    logic [5:0]  w_func;
    logic        w_unused_ir;

    assign w_opcode    = bus.instruction[31:26];
    assign w_func      = bus.instruction[5:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_ir = ^bus.instruction[25:6];

    function automatic logic [2:0] func_to_aluop(input logic [5:0] f);
        case (f)
            FN_SUB:  return OP_SUB;
            FN_AND:  return OP_AND;
            FN_OR:   return OP_OR;
            FN_SLT:  return OP_SLT;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic is_known(input logic [5:0] opc, input logic [5:0] f);
        case (opc)
            OPC_RTYPE: return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
                              (f == FN_OR)  || (f == FN_SLT);
            OPC_J, OPC_BEQ, OPC_ADDI, OPC_LW, OPC_SW: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + 32'd1;
        end
    end

    // Outputs are forced low while reset_n is asserted so an in-flight
    // memory request drops immediately rather than at the next edge.
    always_comb begin
        w_next           = r_state;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = 2'd0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'd0;
        bus.alu_op       = OP_ADD;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.illegal      = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_next       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target precomputed into ALUOut.
                    bus.alu_src_b = 2'd3;
                    w_next = is_known(w_opcode, w_func) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OPC_RTYPE: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_op    = func_to_aluop(w_func);
                            w_next        = S_WB;
                        end
                        OPC_ADDI: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_src_b = 2'd2;
                            w_next        = S_WB;
                        end
                        OPC_LW, OPC_SW: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_src_b = 2'd2;
                            w_next        = S_MEM;
                        end
                        OPC_BEQ: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_op    = OP_SUB;
                            bus.pc_write  = bus.alu_zero;
                            bus.pc_src    = 2'd1;
                            w_next        = S_FETCH;
                        end
                        OPC_J: begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 2'd2;
                            w_next       = S_FETCH;
                        end
                        // IR changed under us after DECODE: treat as illegal.
                        default: w_next = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = (w_opcode == OPC_SW);
                    if (bus.mem_ready)
                        w_next = (w_opcode == OPC_LW) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (w_opcode == OPC_RTYPE);
                    bus.mem_to_reg = (w_opcode == OPC_LW);
                    w_next         = S_FETCH;
                end
                S_TRAP: begin
                    bus.illegal = 1'b1;
                end
                default: w_next = S_TRAP;
            endcase
        end
    end

    assign w_retire = ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) &&
                      (w_next == S_FETCH);

    assign bus.state   = r_state;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t obs();
        ctrl_t c;
        c.mem_req      = bus.mem_req;
        c.mem_we       = bus.mem_we;
        c.mem_addr_sel = bus.mem_addr_sel;
        c.ir_write     = bus.ir_write;
        c.pc_write     = bus.pc_write;
        c.pc_src       = bus.pc_src;
        c.alu_src_a    = bus.alu_src_a;
        c.alu_src_b    = bus.alu_src_b;
        c.alu_op       = bus.alu_op;
        c.reg_write    = bus.reg_write;
        c.reg_dst      = bus.reg_dst;
        c.mem_to_reg   = bus.mem_to_reg;
        c.illegal      = bus.illegal;
        return c;
    endfunction

    // Expected FETCH controls when memory is not ready / ready.
    function automatic ctrl_t fetch_ctrl(input logic rdy);
        ctrl_t e;
        e = '0;
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'd1;
        e.alu_op    = OP_ADD;
        e.ir_write  = rdy;
        e.pc_write  = rdy;
        return e;
    endfunction

    function automatic ctrl_t decode_ctrl();
        ctrl_t e;
        e = '0;
        e.alu_src_b = 2'd3;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.instruction = 32'h00221820;
        bus.mem_ready   = 1'b1;
        bus.alu_zero    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 32'd0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d retired=%0d illegal=%b, expected 0 0 0",
                     bus.state, bus.retired, bus.illegal);
        end
        checks++;
        if (obs() !== ctrl_t'('0)) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%h, expected 0", obs());
        end
    endtask

    task automatic test_rtype();
        ctrl_t e;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.state !== 3'd0 || obs() !== fetch_ctrl(1'b1)) begin
            errors++;
            $display("FAIL rtype_fetch: state=%0d ctrl=%h, expected 0 %h", bus.state, obs(), fetch_ctrl(1'b1));
        end
        tick();
        checks++;
        if (bus.state !== 3'd1 || obs() !== decode_ctrl()) begin
            errors++;
            $display("FAIL rtype_decode: state=%0d ctrl=%h, expected 1 %h", bus.state, obs(), decode_ctrl());
        end
        tick();
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_op = OP_ADD;
        checks++;
        if (bus.state !== 3'd2 || obs() !== e) begin
            errors++;
            $display("FAIL rtype_exec: state=%0d ctrl=%h, expected 2 %h", bus.state, obs(), e);
        end
        tick();
        e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
        checks++;
        if (bus.state !== 3'd4 || obs() !== e || bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL rtype_wb: state=%0d ctrl=%h retired=%0d, expected 4 %h 0", bus.state, obs(), bus.retired, e);
        end
        tick();
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 32'd1) begin
            errors++;
            $display("FAIL rtype_retire: state=%0d retired=%0d, expected 0 1", bus.state, bus.retired);
        end
    endtask

    task automatic test_lw_waits();
        ctrl_t e;
        int    cyc;
        cyc = 0;
        bus.instruction = 32'h8C250008;
        bus.mem_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.state !== 3'd0 || obs() !== fetch_ctrl(1'b0)) begin
                errors++;
                $display("FAIL lw_fetch_wait%0d: state=%0d ctrl=%h, expected 0 %h", i, bus.state, obs(), fetch_ctrl(1'b0));
            end
            tick(); cyc++;
        end
        bus.mem_ready = 1'b1;
        tick(); cyc++;
        // mem_ready stays high here and must be ignored in DECODE/EXEC.
        checks++;
        if (bus.state !== 3'd1) begin
            errors++;
            $display("FAIL lw_decode: state=%0d, expected 1", bus.state);
        end
        tick(); cyc++;
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        checks++;
        if (bus.state !== 3'd2 || obs() !== e) begin
            errors++;
            $display("FAIL lw_exec: state=%0d ctrl=%h, expected 2 %h", bus.state, obs(), e);
        end
        tick(); cyc++;
        bus.mem_ready = 1'b0;
        e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== 3'd3 || obs() !== e) begin
                errors++;
                $display("FAIL lw_mem%0d: state=%0d ctrl=%h, expected 3 %h", i, bus.state, obs(), e);
            end
            tick(); cyc++;
        end
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        checks++;
        if (bus.state !== 3'd4 || obs() !== e) begin
            errors++;
            $display("FAIL lw_wb: state=%0d ctrl=%h, expected 4 %h", bus.state, obs(), e);
        end
        tick(); cyc++;
        checks++;
        if (bus.state !== 3'd0 || cyc != 9 || bus.retired !== 32'd2) begin
            errors++;
            $display("FAIL lw_latency: state=%0d cycles=%0d retired=%0d, expected 0 9 2", bus.state, cyc, bus.retired);
        end
    endtask

    task automatic test_sw();
        ctrl_t e;
        bus.instruction = 32'hAC250008;
        bus.mem_ready   = 1'b1;
        tick(); tick(); tick();
        e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = 1'b1;
        checks++;
        if (bus.state !== 3'd3 || obs() !== e) begin
            errors++;
            $display("FAIL sw_mem: state=%0d ctrl=%h, expected 3 %h", bus.state, obs(), e);
        end
        tick();
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 32'd3) begin
            errors++;
            $display("FAIL sw_return: state=%0d retired=%0d, expected 0 3", bus.state, bus.retired);
        end
    endtask

    task automatic test_beq(input logic zero, input logic [31:0] exp_ret);
        ctrl_t e;
        bus.instruction = 32'h10220003;
        bus.mem_ready   = 1'b1;
        bus.alu_zero    = zero;
        tick(); tick();
        e = '0; e.alu_src_a = 1'b1; e.alu_op = OP_SUB; e.pc_src = 2'd1; e.pc_write = zero;
        checks++;
        if (bus.state !== 3'd2 || obs() !== e) begin
            errors++;
            $display("FAIL beq_exec_z%0b: state=%0d ctrl=%h, expected 2 %h", zero, bus.state, obs(), e);
        end
        tick();
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL beq_return_z%0b: state=%0d retired=%0d, expected 0 %0d", zero, bus.state, bus.retired, exp_ret);
        end
        bus.alu_zero = 1'b0;
    endtask

    task automatic test_jump();
        ctrl_t e;
        bus.instruction = 32'h08000010;
        tick(); tick();
        e = '0; e.pc_write = 1'b1; e.pc_src = 2'd2;
        checks++;
        if (bus.state !== 3'd2 || obs() !== e) begin
            errors++;
            $display("FAIL j_exec: state=%0d ctrl=%h, expected 2 %h", bus.state, obs(), e);
        end
        tick();
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 32'd6) begin
            errors++;
            $display("FAIL j_return: state=%0d retired=%0d, expected 0 6", bus.state, bus.retired);
        end
    endtask

    task automatic test_alu_funcs();
        logic [5:0] fn [4];
        logic [2:0] op [4];
        fn[0] = 6'h22; op[0] = 3'd1;
        fn[1] = 6'h24; op[1] = 3'd2;
        fn[2] = 6'h25; op[2] = 3'd3;
        fn[3] = 6'h2A; op[3] = 3'd4;
        for (int i = 0; i < 4; i++) begin
            bus.instruction = {26'h0008C0, fn[i]};
            tick(); tick();
            checks++;
            if (bus.state !== 3'd2 || bus.alu_op !== op[i]) begin
                errors++;
                $display("FAIL alu_func_%h: state=%0d alu_op=%0d, expected 2 %0d", fn[i], bus.state, bus.alu_op, op[i]);
            end
            tick(); tick();
        end
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== 32'd10) begin
            errors++;
            $display("FAIL alu_funcs_retired: state=%0d retired=%0d, expected 0 10", bus.state, bus.retired);
        end
    endtask

    task automatic test_reset_mid_mem();
        bus.instruction = 32'h8C250008;
        bus.mem_ready   = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd3 || bus.mem_req !== 1'b1 || bus.retired !== 32'd10) begin
            errors++;
            $display("FAIL midmem_before: state=%0d mem_req=%b retired=%0d, expected 3 1 10", bus.state, bus.mem_req, bus.retired);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.mem_req !== 1'b0 || bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL midmem_async_reset: state=%0d mem_req=%b retired=%0d, expected 0 0 0", bus.state, bus.mem_req, bus.retired);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midmem_release: state=%0d mem_req=%b, expected 0 1", bus.state, bus.mem_req);
        end
    endtask

    task automatic test_trap(input logic [31:0] instr, input string tag);
        ctrl_t e;
        bus.instruction = instr;
        bus.mem_ready   = 1'b1;
        tick();
        checks++;
        if (bus.state !== 3'd1) begin
            errors++;
            $display("FAIL trap_%s_decode: state=%0d, expected 1", tag, bus.state);
        end
        tick();
        e = '0; e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.state !== 3'd5 || obs() !== e || bus.retired !== 32'd0) begin
                errors++;
                $display("FAIL trap_%s_hold%0d: state=%0d ctrl=%h retired=%0d, expected 5 %h 0", tag, i, bus.state, obs(), bus.retired, e);
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_%s_clear: state=%0d illegal=%b, expected 0 0", tag, bus.state, bus.illegal);
        end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw();
        test_beq(1'b1, 32'd4);
        test_beq(1'b0, 32'd5);
        test_jump();
        test_alu_funcs();
        test_reset_mid_mem();
        test_trap(32'hFC000000, "opcode3f");
        test_trap(32'h00221821, "badfunc");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state sequencer that drives the shared processor datapath (register file, ALU, single unified memory port, PC and IR registers) over multiple cycles per instruction. It replaces the single-cycle decoder when the datapath is built around one memory port. The controller decodes the latched instruction register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake on memory. It also exposes a retired-instruction counter.

## Interface
- No parameters; opcode/func encodings come from `_const.v`. Values used here: RTYPE 0x00, J 0x02, BEQ 0x04, ADDI 0x08, LW 0x23, SW 0x2B; func ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
- Clock and reset (decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instruction  in  32  IR contents; valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero  in  1  ALU result == 0, combinational from the datapath
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write strobe qualifying mem_req
- mem_addr_sel  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch memory read data into IR
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = {PC[31:28], addr26, 2'b00}
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs data
- alu_src_b  out  2  ALU B input: 0 = rt data, 1 = constant 4, 2 = sext(imm16), 3 = sext(imm16)<<2
- alu_op  out  3  ALU operation code (`OP_*`)
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = memory data register
- state  out  3  current state, for debug
- illegal  out  1  sticky; undecoded instruction trapped
- retired  out  32  count of completed instructions

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. State is registered; all control outputs are combinational from state, instruction, mem_ready and alu_zero. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - While mem_ready=0, stays in FETCH.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (precomputes the branch target into ALUOut).
  - Known opcode/func → EXEC.
  - Anything else → TRAP.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op from func; → WB.
  - ADDI: alu_src_a=1, alu_src_b=2, ADD; → WB.
  - LW/SW: alu_src_a=1, alu_src_b=2, ADD; → MEM.
  - BEQ: alu_src_a=1, alu_src_b=0, SUB; pc_write=alu_zero, pc_src=1; → FETCH.
  - J: pc_write=1, pc_src=2; → FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(opcode==SW); waits for mem_ready.
  - LW → WB.
  - SW → FETCH.
- WB: reg_write=1.
  - R-type: reg_dst=1.
  - ADDI: reg_dst=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - Then → FETCH.
- TRAP: illegal=1 and all enables 0; the FSM stays in TRAP until reset.
- retired increments by 1 (wrapping at 2^32) on every transition into FETCH from EXEC, MEM or WB.

## Timing
- Reset (asynchronous, any cycle):
  - state=FETCH, illegal=0, retired=0.
  - mem_req is asserted combinationally again once reset_n deasserts.
  - An in-flight memory request is abandoned; memory must tolerate a dropped mem_req.
- mem_req, mem_we and mem_addr_sel stay stable from first assertion until the cycle mem_ready=1 is sampled.
- mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory, in cycles from FETCH entry to next FETCH entry:
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - BEQ, J: 3.
  - Each memory wait cycle adds 1 (per FETCH or MEM).
- In the BEQ EXEC cycle, alu_zero is sampled combinationally; both PC updates (the FETCH PC+4 and the branch) land on distinct edges.
- ir_write and pc_write are single-cycle pulses per instruction, except that a not-taken BEQ has no second pc_write.

## Test plan
- Reset with mem_ready=1, IR=ADD r3,r1,r2 (0x00221820) → state sequence 0,1,2,4,0; reg_write=1 and reg_dst=1 in WB only; retired=1 after 4 cycles.
- LW r5,8(r1) (0x8C250008), mem_ready low for 2 cycles in both FETCH and MEM → 9 cycles total; mem_to_reg=1 in WB; mem_we=0 throughout.
- SW (0xAC250008) → MEM has mem_we=1 and mem_addr_sel=1; no WB state; 4 cycles.
- BEQ (0x10220003):
  - alu_zero=1 in EXEC → pc_write=1, pc_src=1.
  - alu_zero=0 → pc_write=0.
  - Both return to FETCH after 3 cycles.
- Opcode 0x3F → DECODE→TRAP; illegal=1 persists for 20 cycles with no enables; reset_n low clears it.
- reset_n pulsed low mid-MEM with mem_req=1 → state=0 and mem_req drops immediately (asynchronously); retired unchanged until cleared, then 0.
